bus_mem_responder: RTL and testbench

Responder end of the CPU16 memory bus. It decodes every CPU bus cycle into an on-chip word RAM or a small memory-mapped I/O page (LED latch, synchronized switches, prescaled timer), and returns read data with a fixed latency. The CPU16 core inserts its decode/compute wait states against this latency. The block sits between the CPU16 core and the board pins in the game top level.

---
 rtl/bus_mem_responder_pkg.sv | 30 +++
 rtl/bus_mem_responder_if.sv | 12 +
 rtl/bus_mem_responder_timer.sv | 56 +++++
 rtl/bus_mem_responder.sv | 135 +++++++++++++
 tb/tb_bus_mem_responder.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/bus_mem_responder_pkg.sv
// Shared constants and types for the CPU16 memory-bus responder.
package bus_mem_pkg;

  localparam int DATA_W = 16;

  // Word offsets inside the 4-word I/O page
  localparam logic [1:0] IO_LED    = 2'd0;
  localparam logic [1:0] IO_SW     = 2'd1;
  localparam logic [1:0] IO_TIMER  = 2'd2;
  localparam logic [1:0] IO_STATUS = 2'd3;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_IO   = 2'd1,
    REG_NONE = 2'd2
  } region_e;

  // RAM wins if the two windows ever overlap (only possible at RAM_ADDR_W=16).
  function automatic region_e decode_region(input logic [DATA_W-1:0] addr,
                                            input int                ram_aw,
                                            input logic [DATA_W-1:0] io_base);
    if ({1'b0, addr} < (17'd1 << ram_aw))
      return REG_RAM;
    else if (addr[DATA_W-1:2] == io_base[DATA_W-1:2])
      return REG_IO;
    else
      return REG_NONE;
  endfunction

endpackage

// File: rtl/bus_mem_responder_if.sv
// CPU16 memory-bus signal bundle; the CPU is master, the responder is slave.
interface bus_mem_responder_if;
  import bus_mem_pkg::*;

  logic [DATA_W-1:0] address;
  logic [DATA_W-1:0] data_in;   // CPU write data
  logic              write;
  logic [DATA_W-1:0] data_out;  // read data back to CPU

  modport master (output address, output data_in, output write, input data_out);
  modport slave  (input address, input data_in, input write, output data_out);
endinterface

// File: rtl/bus_mem_responder_timer.sv
// Prescaled 16-bit timer with sticky overflow flag.
// A CPU load beats a same-cycle increment and restarts the prescaler;
// an overflow beats a same-cycle write-1-clear so the event is never lost.
module bus_timer
  import bus_mem_pkg::*;
#(
  parameter int PRESCALE = 50000
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_val,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_count,
  output logic              o_ovf
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [15:0]       r_pre;
  logic [DATA_W-1:0] r_count;
  logic              r_ovf;
  logic              w_wrap;
  logic              w_set;

  assign w_wrap = (r_pre == PRE_MAX);
  // Overflow only counts when the increment actually lands (not overridden by a load)
  assign w_set  = w_wrap && !i_load && (r_count == 16'hFFFF);

  // Prescaler and count; load has priority over the tick
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre   <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_pre   <= '0;
      r_count <= i_load_val;
    end else if (w_wrap) begin
      r_pre   <= '0;
      r_count <= r_count + 16'd1;
    end else begin
      r_pre   <= r_pre + 16'd1;
    end
  end

  // Sticky overflow; set beats clear
  always_ff @(posedge clk) begin
    if (reset)      r_ovf <= 1'b0;
    else if (w_set) r_ovf <= 1'b1;
    else if (i_clr) r_ovf <= 1'b0;
  end

  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/bus_mem_responder.sv
// CPU16 memory-bus responder: word RAM at 0x0000 plus a 4-word I/O page
// (LED, synchronized switches, timer, status). Reads are read-first with
// one cycle of latency. Define RAM_WAIT_EN to add an output register and
// make the latency two cycles.
module bus_mem_responder
  import bus_mem_pkg::*;
#(
  parameter int                RAM_ADDR_W = 10,
  parameter logic [DATA_W-1:0] IO_BASE    = 16'hFF00,
  parameter int                PRESCALE   = 50000
)(
  input  logic                clk,
  input  logic                reset,
  bus_mem_responder_if.slave  bus,
  input  logic [DATA_W-1:0]   sw_in,
  output logic [DATA_W-1:0]   led_out
);

  localparam int RAM_DEPTH = 1 << RAM_ADDR_W;

  logic [DATA_W-1:0]     r_mem [RAM_DEPTH];
  logic [DATA_W-1:0]     r_ram_q;
  logic [DATA_W-1:0]     r_io_q;
  region_e               r_region_q;
  logic [DATA_W-1:0]     r_led;
  logic [DATA_W-1:0]     r_sw_meta;
  logic [DATA_W-1:0]     r_sw_sync;

  region_e               w_region;
  logic [1:0]            w_io_off;
  logic [RAM_ADDR_W-1:0] w_ram_idx;
  logic                  w_ram_we;
  logic                  w_io_we;
  logic                  w_tmr_load;
  logic                  w_tmr_clr;
  logic [DATA_W-1:0]     w_tmr_count;
  logic                  w_tmr_ovf;
  logic [DATA_W-1:0]     w_io_rd;
  logic [DATA_W-1:0]     w_rd;

  assign w_region   = decode_region(bus.address, RAM_ADDR_W, IO_BASE);
  assign w_io_off   = bus.address[1:0];
  assign w_ram_idx  = bus.address[RAM_ADDR_W-1:0];
  assign w_ram_we   = bus.write && (w_region == REG_RAM);
  assign w_io_we    = bus.write && (w_region == REG_IO);
  assign w_tmr_load = w_io_we && (w_io_off == IO_TIMER);
  assign w_tmr_clr  = w_io_we && (w_io_off == IO_STATUS) && bus.data_in[0];

  // RAM write port; deliberately outside reset so a write during reset still lands
  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_ram_idx] <= bus.data_in;
  end

  // RAM read port, read-first: captures the word before any same-edge write
  always_ff @(posedge clk) begin
    r_ram_q <= r_mem[w_ram_idx];
  end

  // Two-flop switch synchronizer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
    end
  end

  // LED latch; reset overrides a coincident write
  always_ff @(posedge clk) begin
    if (reset)                               r_led <= '0;
    else if (w_io_we && w_io_off == IO_LED)  r_led <= bus.data_in;
  end

  bus_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (bus.data_in),
    .i_clr      (w_tmr_clr),
    .o_count    (w_tmr_count),
    .o_ovf      (w_tmr_ovf)
  );

  // I/O page read mux, evaluated on pre-update register values
  always_comb begin
    w_io_rd = '0;
    case (w_io_off)
      IO_LED:    w_io_rd = r_led;
      IO_SW:     w_io_rd = r_sw_sync;
      IO_TIMER:  w_io_rd = w_tmr_count;
      IO_STATUS: w_io_rd = {{(DATA_W-1){1'b0}}, w_tmr_ovf};
      default:   w_io_rd = '0;
    endcase
  end

  // Capture the region and I/O read data at the address-sample edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_region_q <= REG_NONE;
      r_io_q     <= '0;
    end else begin
      r_region_q <= w_region;
      r_io_q     <= w_io_rd;
    end
  end

  // Final read mux; unmapped or just-reset reads return zero
  always_comb begin
    w_rd = '0;
    case (r_region_q)
      REG_RAM: w_rd = r_ram_q;
      REG_IO:  w_rd = r_io_q;
      default: w_rd = '0;
    endcase
  end

`ifdef RAM_WAIT_EN
  logic [DATA_W-1:0] r_dout2;

  // Extra output stage for the wait-state CPU build
  always_ff @(posedge clk) begin
    if (reset) r_dout2 <= '0;
    else       r_dout2 <= w_rd;
  end

  assign bus.data_out = r_dout2;
`else
  assign bus.data_out = w_rd;
`endif

  assign led_out = r_led;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed self-checking bench for bus_mem_responder (RAM_ADDR_W=10, PRESCALE=4).
module tb_bus_mem_responder;
  import bus_mem_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       sw_in;
  logic [15:0]       led_out;
  int                n_checks = 0;
  int                n_fails  = 0;

  bus_mem_responder_if u_bus ();

  bus_mem_responder #(
    .RAM_ADDR_W (10),
    .IO_BASE    (16'hFF00),
    .PRESCALE   (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (u_bus),
    .sw_in   (sw_in),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    u_bus.address = a;
    u_bus.data_in = d;
    u_bus.write   = 1'b1;
    tick();
    u_bus.write   = 1'b0;
  endtask

  // Present addr for n edges (plus the wait stage if built), then check data_out
  task automatic rd(input logic [15:0] a, input int n, input logic [15:0] exp, input string tag);
    u_bus.address = a;
    u_bus.write   = 1'b0;
    repeat (n) tick();
`ifdef RAM_WAIT_EN
    tick();
`endif
    chk(tag, u_bus.data_out, exp);
  endtask

  initial begin
    reset         = 1'b1;
    sw_in         = 16'h0000;
    u_bus.address = 16'h0000;
    u_bus.data_in = 16'h0000;
    u_bus.write   = 1'b0;
    repeat (2) tick();
    chk("rst_dout", u_bus.data_out, 16'h0000);
    chk("rst_led", led_out, 16'h0000);
    reset = 1'b0;
    rd(16'hFF02, 1, 16'h0000, "rst_timer");
    rd(16'hFF03, 1, 16'h0000, "rst_status");

    // RAM round trip
    wr(16'h0004, 16'h5A5A);
    wr(16'h0003, 16'hBEEF);
    rd(16'h0003, 1, 16'hBEEF, "ram_3");
    rd(16'h0004, 1, 16'h5A5A, "ram_4");

    // Read-first collision
    wr(16'h0010, 16'h1111);
    u_bus.address = 16'h0010;
    u_bus.data_in = 16'h2222;
    u_bus.write   = 1'b1;
    tick();
    u_bus.write   = 1'b0;
`ifdef RAM_WAIT_EN
    tick();
`endif
    chk("rf_old", u_bus.data_out, 16'h1111);
    rd(16'h0010, 1, 16'h2222, "rf_new");

    // LED latch
    wr(16'hFF00, 16'h00A5);
    chk("led_wr", led_out, 16'h00A5);
    rd(16'hFF00, 1, 16'h00A5, "led_rd");

    // Switches through synchronizer; writes to SW ignored
    sw_in = 16'h8001;
    repeat (3) tick();
    rd(16'hFF01, 1, 16'h8001, "sw_rd");
    wr(16'hFF01, 16'h1234);
    rd(16'hFF01, 1, 16'h8001, "sw_ro");
    chk("sw_wr_led", led_out, 16'h00A5);

    // Unmapped and boundary
    wr(16'h0000, 16'hCAFE);
    rd(16'h0400, 1, 16'h0000, "unm_400");
    rd(16'hFF04, 1, 16'h0000, "unm_ff04");
    wr(16'h0400, 16'h1234);
    wr(16'hFF04, 16'hFFFF);
    rd(16'h0000, 1, 16'hCAFE, "no_alias");
    chk("unm_led", led_out, 16'h00A5);

    // Timer overflow: load FFFE, wraps to 0 after 8 clocks
    wr(16'hFF02, 16'hFFFE);
    rd(16'hFF02, 8, 16'hFFFF, "tmr_ffff");
    rd(16'hFF02, 1, 16'h0000, "tmr_wrap");
    rd(16'hFF03, 1, 16'h0001, "stat_set");
    wr(16'hFF03, 16'h0001);
    rd(16'hFF03, 1, 16'h0000, "stat_clr");

    // Clear coincident with overflow: overflow lands on the 4th edge after load
    wr(16'hFF02, 16'hFFFF);
    repeat (3) tick();
    wr(16'hFF03, 16'h0001);
    rd(16'hFF03, 1, 16'h0001, "stat_coll");

    // Load coincident with increment: written value wins
    wr(16'hFF02, 16'h0000);
    repeat (3) tick();
    wr(16'hFF02, 16'h0100);
    rd(16'hFF02, 1, 16'h0100, "tmr_coll");

    // Reset mid-run with a RAM write and an LED write pending
    wr(16'hFF00, 16'hFFFF);
    chk("led_ffff", led_out, 16'hFFFF);
    rd(16'h0003, 1, 16'hBEEF, "pre_rst");
    reset         = 1'b1;
    u_bus.address = 16'h0020;
    u_bus.data_in = 16'h7777;
    u_bus.write   = 1'b1;
    tick();
    u_bus.write   = 1'b0;
    chk("mid_rst_led", led_out, 16'h0000);
    chk("mid_rst_dout", u_bus.data_out, 16'h0000);
    tick();
    reset = 1'b0;
    rd(16'hFF02, 1, 16'h0000, "mid_rst_tmr");
    rd(16'h0020, 1, 16'h7777, "rst_ram_wr");
    rd(16'h0003, 1, 16'hBEEF, "ram_kept");
    chk("led_post", led_out, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
